// File: rtl/round_key_scheduler.sv
// Round key scheduler: walks NUM_ROUNDS rounds through an external 32->256 key
// expander, assembling two expansions into each 512-bit round key.
module round_key_scheduler #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [31:0]  key_in,
  output logic [31:0]  exp_key,
  output logic [31:0]  exp_stage,
  input  logic [255:0] exp_expanded,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [511:0] rk_data,
  output logic [7:0]   rk_index,
  output logic         rk_last,
  output logic         busy,
  output logic         done
);

  localparam logic [7:0] LAST_ROUND = 8'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, GEN_HI, GEN_LO, OUT} state_t;

  state_t       state_q, state_d;
  logic [31:0]  key_reg_q, key_reg_d;
  logic [7:0]   round_q, round_d;
  logic [511:0] rk_data_q, rk_data_d;
  logic         rk_valid_q, rk_valid_d;
  logic         rk_last_q, rk_last_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [31:0]  exp_stage_q, exp_stage_d;

  always_comb begin
    state_d   = state_q;
    key_reg_d = key_reg_q;
    round_d   = round_q;
    rk_data_d = rk_data_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_reg_d = key_in;
          round_d   = 8'd0;
          state_d   = GEN_HI;
        end
      end
      GEN_HI: begin
        rk_data_d[511:256] = exp_expanded;
        state_d            = GEN_LO;
      end
      GEN_LO: begin
        rk_data_d[255:0] = exp_expanded;
        state_d          = OUT;
      end
      OUT: begin
        if (rk_ready) begin
          if (round_q == LAST_ROUND) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_reg_d = {key_reg_q[26:0], key_reg_q[31:27]} ^ {24'b0, round_q};
            round_d   = round_q + 8'd1;
            state_d   = GEN_HI;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered.
    rk_valid_d = (state_d == OUT);
    busy_d     = (state_d != IDLE);
    rk_last_d  = (state_d == OUT) && (round_d == LAST_ROUND);
    case (state_d)
      GEN_HI:  exp_stage_d = {23'b0, round_d, 1'b0};
      GEN_LO:  exp_stage_d = {23'b0, round_d, 1'b1};
      default: exp_stage_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      key_reg_q   <= 32'd0;
      round_q     <= 8'd0;
      rk_data_q   <= 512'd0;
      rk_valid_q  <= 1'b0;
      rk_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      exp_stage_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      key_reg_q   <= key_reg_d;
      round_q     <= round_d;
      rk_data_q   <= rk_data_d;
      rk_valid_q  <= rk_valid_d;
      rk_last_q   <= rk_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      exp_stage_q <= exp_stage_d;
    end
  end

  assign exp_key   = key_reg_q;
  assign exp_stage = exp_stage_q;
  assign rk_valid  = rk_valid_q;
  assign rk_data   = rk_data_q;
  assign rk_index  = round_q;
  assign rk_last   = rk_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_round_key_scheduler.sv
// Scoreboard bench for round_key_scheduler with a reference expander and a
// second single-round instance.
module tb_round_key_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1, start = 1'b0, rk_ready = 1'b1;
  logic [31:0]  key_in = 32'd0, exp_key, exp_stage;
  logic [255:0] exp_expanded;
  logic         rk_valid, rk_last, busy, done;
  logic [511:0] rk_data;
  logic [7:0]   rk_index;

  logic         start1 = 1'b0, rk_ready1 = 1'b1;
  logic [31:0]  key_in1 = 32'd0, exp_key1, exp_stage1;
  logic [255:0] exp_expanded1;
  logic         rk_valid1, rk_last1, busy1, done1;
  logic [511:0] rk_data1;
  logic [7:0]   rk_index1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, errors = 0;

  typedef struct {
    logic [511:0] data;
    logic [7:0]   idx;
    logic         last;
  } exp_t;
  exp_t sb[$];

  function automatic logic [255:0] mix(input logic [31:0] k, input logic [31:0] s);
    logic [255:0] r;
    logic [31:0]  w;
    for (int i = 0; i < 8; i++) begin
      w = (k << i) | (k >> (32 - i));
      w = w ^ (s * 32'h9E3779B9) ^ (32'(i) << 24);
      r[i*32 +: 32] = w;
    end
    return r;
  endfunction

  function automatic logic [31:0] key_at(input logic [31:0] k0, input int r);
    logic [31:0] k;
    k = k0;
    for (int j = 0; j < r; j++) k = {k[26:0], k[31:27]} ^ {24'b0, 8'(j)};
    return k;
  endfunction

  function automatic logic [511:0] rk_at(input logic [31:0] k0, input int r);
    logic [31:0] k;
    k = key_at(k0, r);
    return {mix(k, {23'b0, 8'(r), 1'b0}), mix(k, {23'b0, 8'(r), 1'b1})};
  endfunction

  assign exp_expanded  = mix(exp_key, exp_stage);
  assign exp_expanded1 = mix(exp_key1, exp_stage1);

  round_key_scheduler #(.NUM_ROUNDS(16)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .exp_key(exp_key), .exp_stage(exp_stage), .exp_expanded(exp_expanded),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
    .rk_index(rk_index), .rk_last(rk_last), .busy(busy), .done(done)
  );

  round_key_scheduler #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .key_in(key_in1),
    .exp_key(exp_key1), .exp_stage(exp_stage1), .exp_expanded(exp_expanded1),
    .rk_valid(rk_valid1), .rk_ready(rk_ready1), .rk_data(rk_data1),
    .rk_index(rk_index1), .rk_last(rk_last1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string n, input logic [511:0] act, input logic [511:0] want);
    vectors++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, act, want);
    end
  endtask

  task automatic timeout(input string n);
    vectors++;
    errors++;
    $display("FAIL %s: timed out", n);
  endtask

  task automatic push_exp(input logic [31:0] k0, input int n);
    exp_t e;
    for (int r = 0; r < n; r++) begin
      e.data = rk_at(k0, r);
      e.idx  = 8'(r);
      e.last = (r == n - 1);
      sb.push_back(e);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake and checks the done pulse.
  logic pend = 1'b0, check_gap = 1'b0, have_prev = 1'b0;
  int   last_pop = 0;
  always @(negedge clk) begin
    logic exp_now;
    exp_t e;
    exp_now = pend;
    pend = 1'b0;
    if (!rst) begin
      if (done || exp_now) chk("done_pulse", 512'(done), 512'(exp_now));
      if (rk_valid && rk_ready) begin
        if (sb.size() == 0) begin
          timeout("unexpected_rk");
        end else begin
          e = sb.pop_front();
          chk("rk_data", rk_data, e.data);
          chk("rk_index", 512'(rk_index), 512'(e.idx));
          chk("rk_last", 512'(rk_last), 512'(e.last));
          if (check_gap && have_prev) chk("rk_gap", 512'(cyc - last_pop), 512'd3);
          have_prev = 1'b1;
          last_pop  = cyc;
          if (e.last) pend = 1'b1;
        end
      end
    end
  end

  task automatic start_run(input logic [31:0] k, output int t);
    @(posedge clk); #1;
    key_in = k;
    start  = 1'b1;
    t      = cyc;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic wait_first_valid(input int t);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rk_valid) begin ok = 1'b1; break; end
    end
    if (ok) chk("latency", 512'(cyc - t), 512'd3);
    else timeout("first_valid");
  endtask

  task automatic wait_done(input bit chain, input logic [31:0] nk);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (done) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("done_wait");
    else begin
      chk("busy_at_done", 512'(busy), 512'd0);
      if (chain) begin
        push_exp(nk, 16);
        have_prev = 1'b0;
        key_in = nk;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, ta;
    bit ok;
    logic [31:0] kt [3];
    kt[0] = 32'h80000001; kt[1] = 32'h00000030; kt[2] = 32'h00000601;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 512'({rk_valid, rk_last, busy, done}), 512'd0);
    chk("rst_data", rk_data, 512'd0);
    chk("rst_index_key", 512'({rk_index, exp_key, exp_stage}), 512'd0);
    chk("rst1_outs", 512'({rk_valid1, rk_last1, busy1, done1, rk_index1, exp_key1}), 512'd0);
    rst = 1'b0;

    // Basic 16-round schedule with continuous ready
    push_exp(32'h01234567, 16);
    check_gap = 1'b1; have_prev = 1'b0;
    start_run(32'h01234567, t);
    wait_first_valid(t);
    wait_done(1'b0, 32'd0);

    // Key evolution seen on exp_key
    push_exp(32'h80000001, 16);
    have_prev = 1'b0;
    start_run(32'h80000001, t);
    for (int k = 0; k < 3; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (rk_valid && rk_index == 8'(k)) begin ok = 1'b1; break; end
      end
      if (ok) chk("exp_key_round", 512'(exp_key), 512'(kt[k]));
      else timeout("exp_key_round");
    end
    wait_done(1'b0, 32'd0);

    // Backpressure in round 3
    check_gap = 1'b0;
    push_exp(32'hA5A5F00F, 16);
    start_run(32'hA5A5F00F, t);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rk_index == 8'd3) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("reach_round3");
    rk_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("stall_valid", 512'(rk_valid), 512'd1);
      chk("stall_index", 512'(rk_index), 512'd3);
      chk("stall_data", rk_data, rk_at(32'hA5A5F00F, 3));
    end
    rk_ready = 1'b1;
    @(negedge clk);
    ta = cyc;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rk_valid) begin ok = 1'b1; break; end
    end
    if (ok) begin
      chk("resume_gap", 512'(cyc - ta), 512'd3);
      chk("resume_index", 512'(rk_index), 512'd4);
    end else timeout("resume_valid");
    wait_done(1'b0, 32'd0);

    // start while busy is ignored
    push_exp(32'h13579BDF, 16);
    start_run(32'h13579BDF, t);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rk_index == 8'd5) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("reach_round5");
    key_in = 32'hFFFFFFFF;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    wait_done(1'b0, 32'd0);

    // Reset in GEN_LO of round 7, then cold restart and a start on the done cycle
    push_exp(32'h0BADF00D, 16);
    start_run(32'h0BADF00D, t);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (exp_stage == 32'd15) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("reach_genlo7");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    pend = 1'b0;
    chk("abort_flags", 512'({rk_valid, rk_last, busy, done}), 512'd0);
    chk("abort_data", rk_data, 512'd0);
    chk("abort_index_key", 512'({rk_index, exp_key, exp_stage}), 512'd0);
    repeat (12) @(negedge clk);
    check_gap = 1'b1; have_prev = 1'b0;
    push_exp(32'h01234567, 16);
    start_run(32'h01234567, t);
    wait_first_valid(t);
    wait_done(1'b1, 32'h2468ACE0);
    wait_done(1'b0, 32'd0);
    chk("sb_drained", 512'(sb.size()), 512'd0);

    // Single-round instance
    @(posedge clk); #1;
    key_in1 = 32'd0;
    start1  = 1'b1;
    @(posedge clk); #1;
    start1  = 1'b0;
    chk("n1_stage_hi", 512'({busy1, exp_stage1}), 512'({1'b1, 32'd0}));
    @(posedge clk); #1;
    chk("n1_stage_lo", 512'(exp_stage1), 512'd1);
    @(posedge clk); #1;
    chk("n1_valid", 512'({rk_valid1, rk_index1, rk_last1}), 512'({1'b1, 8'd0, 1'b1}));
    chk("n1_data", rk_data1, {mix(32'd0, 32'd0), mix(32'd0, 32'd1)});
    @(posedge clk); #1;
    chk("n1_done", 512'({done1, busy1, rk_valid1}), 512'({1'b1, 1'b0, 1'b0}));
    @(posedge clk); #1;
    chk("n1_done_clear", 512'({done1, busy1}), 512'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/round_key_scheduler.md
ROUND_KEY_SCHEDULER -- requirements
Module: round_key_scheduler

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 16, meaning round keys generated per load (legal 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  begin schedule; sampled only in IDLE.
REQ-005 SHALL have port key_in  input  32  master key, captured on accepted start.
REQ-006 SHALL have port exp_key  output  32  key driven to the 32-to-256 key expander.
REQ-007 SHALL have port exp_stage  output  32  stage driven to the expander.
REQ-008 SHALL have port exp_expanded  input  256  expander result, combinational from exp_key/exp_stage.
REQ-009 SHALL have port rk_valid  output  1  round key available.
REQ-010 SHALL have port rk_ready  input  1  consumer accepts round key.
REQ-011 SHALL have port rk_data  output  512  round key {hi 256, lo 256}.
REQ-012 SHALL have port rk_index  output  8  round number of rk_data, 0-based.
REQ-013 SHALL have port rk_last  output  1  high with rk_valid on round NUM_ROUNDS-1.
REQ-014 SHALL have port busy  output  1  high in any state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse after last round accepted.

Function
REQ-016 SHALL implement FSM states IDLE, GEN_HI, GEN_LO, OUT.
REQ-017 IDLE: start=1 -> load key_reg<=key_in, round<=0, go GEN_HI; start=0 -> stay.
REQ-018 GEN_HI: exp_stage = {23'b0, round, 1'b0}; capture exp_expanded into rk_data[511:256]; go GEN_LO.
REQ-019 GEN_LO: exp_stage = {23'b0, round, 1'b1}; capture exp_expanded into rk_data[255:0]; go OUT.
REQ-020 In IDLE and OUT, exp_stage SHALL be 0; exp_key SHALL always equal key_reg.
REQ-021 OUT: rk_valid=1; rk_data, rk_index=round, rk_last SHALL hold stable while rk_ready=0.
REQ-022 OUT with rk_ready=1 and round<NUM_ROUNDS-1: key_reg <= rotl(key_reg,5) ^ {24'b0, round}; round<=round+1; go GEN_HI.
REQ-023 OUT with rk_ready=1 and round=NUM_ROUNDS-1: go IDLE; done=1 next cycle only; key_reg unchanged.
REQ-024 Latency: start accepted cycle t -> rk_valid first high cycle t+3; with rk_ready held 1, one round key every 3 cycles.
REQ-025 start while busy SHALL be ignored, no effect on key_reg, round or state.
REQ-026 rk_valid SHALL never be high outside OUT; it SHALL not drop before handshake.
REQ-027 NUM_ROUNDS=1: single round key with rk_index=0, rk_last=1, then done.
REQ-028 round counter SHALL not wrap; it never exceeds NUM_ROUNDS-1.
REQ-029 start asserted on the cycle done pulses SHALL be accepted (state is IDLE).

Reset
REQ-030 rst=1 SHALL, on the next edge, force IDLE, key_reg=0, round=0, rk_data=0, rk_valid=0, rk_last=0, rk_index=0, busy=0, done=0, from any state.
REQ-031 rst mid-schedule SHALL abort with no further rk_valid or done pulse; rst SHALL take priority over start and rk_ready.
REQ-032 After reset release, first start SHALL behave identically to a cold start.

Verification
REQ-033 Basic: key_in=32'h01234567, start 1 cycle, rk_ready=1 -> rk_valid at t+3, rk_index 0..15 every 3 cycles, rk_last with index 15, done one cycle after; rk_data matches reference expander model.
REQ-034 Key evolution: key_in=32'h80000001 -> exp_key round0=32'h80000001, round1=rotl5=32'h00000030 ^ 0 = 32'h00000030, round2=32'h00000600^1=32'h00000601.
REQ-035 Backpressure: rk_ready=0 for 10 cycles in round 3 -> rk_valid, rk_data, rk_index=3 stable; resume yields index 4 three cycles after accept.
REQ-036 start during busy (round 5) with key_in=32'hFFFFFFFF -> ignored; later round keys unchanged vs. undisturbed run.
REQ-037 rst asserted in GEN_LO of round 7 -> next cycle all outputs zero, state IDLE, no done; new start runs full 16 rounds.
REQ-038 NUM_ROUNDS=1, key_in=0 -> single rk_valid with rk_index=0, rk_last=1, exp_stage 0 then 1, done pulse, busy low after.
